// File: rtl/tdm_pkg.sv
// Shared TDM definitions: framing state encoding and default channel count,
// common to this receiver and the matching transmitter.
package tdm_pkg;

  localparam int TDM_CH = 8;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux8_slot_ctr.sv
// Slot counter for the TDM demux: clear, load-to-1 on frame start, and
// natural power-of-two wrap on increment.
module slot_ctr #(
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SW'(1);
    end else if (en) begin
      cnt <= cnt + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// Serial TDM demultiplexer: collects one bit per slot into a shadow register
// and publishes a complete frame on y with a one-cycle valid pulse.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter  int CH = TDM_CH,
  localparam int SW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          en,
  input  logic          frame,
  output logic [CH-1:0] y,
  output logic          valid,
  output logic [SW-1:0] slot,
  output logic          sync_err,
  output logic          locked
);

  localparam logic [SW-1:0] LAST = SW'(CH - 1);

  state_t        state, state_nxt;
  logic          ctr_inc, ctr_load1, ctr_clr;
  logic          restart, wr, y_load;
  logic          valid_nxt, err_nxt;
  logic [CH-2:0] shadow, shadow_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      valid    <= valid_nxt;
      sync_err <= err_nxt;
    end
  end

  // A frame marker always restarts collection; the error pulse only flags it
  // when it lands in the middle of a frame that was being assembled.
  always_comb begin
    state_nxt = state;
    ctr_inc   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_clr   = 1'b0;
    restart   = 1'b0;
    wr        = 1'b0;
    y_load    = 1'b0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (en) begin
      if (frame) begin
        restart   = 1'b1;
        ctr_load1 = 1'b1;
        state_nxt = LOCK;
        err_nxt   = (state == LOCK) && (slot != '0);
      end else if (state == LOCK) begin
        if (slot == '0) begin
          err_nxt   = 1'b1;
          ctr_clr   = 1'b1;
          state_nxt = HUNT;
        end else begin
          ctr_inc = 1'b1;
          if (slot == LAST) begin
            y_load    = 1'b1;
            valid_nxt = 1'b1;
          end else begin
            wr = 1'b1;
          end
        end
      end
    end
  end

  // The last slot bit goes straight to y, so the shadow only holds CH-1 bits.
  always_comb begin
    shadow_we = '0;
    for (int k = 0; k < CH - 1; k++) begin
      shadow_we[k] = wr && (slot == SW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      y      <= '0;
    end else begin
      if (restart) begin
        shadow    <= '0;
        shadow[0] <= din;
      end else begin
        for (int k = 0; k < CH - 1; k++) begin
          if (shadow_we[k]) shadow[k] <= din;
        end
      end
      if (y_load) y <= {din, shadow};
    end
  end

  slot_ctr #(.SW(SW)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctr_inc),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .cnt   (slot)
  );

  assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8 (CH=8): a fixed vector table, directed framing
// sequences and a randomized run, all against a frame-level reference model.
module tb_tdm_demux8;

  localparam int CH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          din = 1'b0;
  logic          en = 1'b0;
  logic          frame = 1'b0;
  logic [CH-1:0] y;
  logic          valid;
  logic [2:0]    slot;
  logic          sync_err;
  logic          locked;

  tdm_demux8 #(.CH(CH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .en       (en),
    .frame    (frame),
    .y        (y),
    .valid    (valid),
    .slot     (slot),
    .sync_err (sync_err),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int vcount = 0;
  int ecount = 0;

  // Reference model: what has been collected of the current frame.
  bit            m_lock;
  int            m_pos;
  bit            m_bits[CH];
  logic [CH-1:0] m_y;
  bit            m_valid, m_err;

  typedef struct {
    bit         en, fr, din;
    logic [7:0] y;
    bit         v;
    int         s;
    bit         err, lk;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_pos = 0; m_y = '0; m_valid = 0; m_err = 0;
    for (int k = 0; k < CH; k++) m_bits[k] = 0;
  endtask

  task automatic model_step(input bit e, input bit f, input bit d);
    m_valid = 0;
    m_err   = 0;
    if (e) begin
      if (f) begin
        if (m_lock && m_pos != 0) m_err = 1;
        for (int k = 0; k < CH; k++) m_bits[k] = 0;
        m_bits[0] = d;
        m_pos  = 1;
        m_lock = 1;
      end else if (m_lock) begin
        if (m_pos == 0) begin
          m_err  = 1;
          m_lock = 0;
        end else begin
          m_bits[m_pos] = d;
          if (m_pos == CH - 1) begin
            for (int k = 0; k < CH; k++) m_y[k] = m_bits[k];
            m_valid = 1;
            m_pos   = 0;
          end else begin
            m_pos++;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    chk("y", y, m_y);
    chk("valid", valid, m_valid);
    chk("slot", slot, m_pos);
    chk("sync_err", sync_err, m_err);
    chk("locked", locked, m_lock);
    chk("pulse_excl", valid & sync_err, 0);
  endtask

  task automatic drive(input bit e, input bit f, input bit d);
    en = e; frame = f; din = d;
    @(posedge clk);
    model_step(e, f, d);
    #1;
    vcount += valid;
    ecount += sync_err;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [7:0] b, input int gap);
    for (int i = 0; i < CH; i++) begin
      drive(1'b1, i == 0, b[i]);
      idle(gap);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_slot"}, slot, 0);
    chk({tag, "_err"}, sync_err, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1, 1, 1, 8'h00, 0, 1, 0, 1};
    tbl[1] = '{1, 0, 0, 8'h00, 0, 2, 0, 1};
    tbl[2] = '{1, 0, 1, 8'h00, 0, 3, 0, 1};
    tbl[3] = '{1, 0, 1, 8'h00, 0, 4, 0, 1};
    tbl[4] = '{1, 0, 0, 8'h00, 0, 5, 0, 1};
    tbl[5] = '{1, 0, 0, 8'h00, 0, 6, 0, 1};
    tbl[6] = '{1, 0, 1, 8'h00, 0, 7, 0, 1};
    tbl[7] = '{1, 0, 0, 8'b01001101, 1, 0, 0, 1};
    tbl[8] = '{0, 0, 0, 8'b01001101, 0, 0, 0, 1};

    model_reset();
    #1 rst_n = 1'b0;
    #2 check_zero("rst_init");
    #19 rst_n = 1'b1;

    // Frame marker with en=0 in HUNT is ignored.
    drive(1'b0, 1'b1, 1'b1);
    chk("hunt_noen_locked", locked, 0);
    chk("hunt_noen_err", sync_err, 0);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].en, tbl[i].fr, tbl[i].din);
      chk($sformatf("tbl%0d_y", i), y, tbl[i].y);
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].v);
      chk($sformatf("tbl%0d_slot", i), slot, tbl[i].s);
      chk($sformatf("tbl%0d_err", i), sync_err, tbl[i].err);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
    end

    // Back-to-back frames with en every second cycle.
    vcount = 0; ecount = 0;
    for (int i = 0; i < CH; i++) begin
      drive(1'b1, i == 0, 1'((8'hA5 >> i) & 8'h01));
      if (i == CH - 1) chk("b2b_y_a5", y, 8'hA5);
      idle(1);
    end
    send_frame(8'h3C, 1);
    chk("b2b_y_3c", y, 8'h3C);
    chk("b2b_valid_count", vcount, 2);
    chk("b2b_err_count", ecount, 0);

    // Early frame at slot 5 restarts collection without touching y.
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'((8'h5A >> i) & 8'h01));
    chk("early_pre_slot", slot, 5);
    drive(1'b1, 1'b1, 1'b1);
    chk("early_err", sync_err, 1);
    chk("early_y_hold", y, 8'h3C);
    chk("early_slot", slot, 1);
    for (int i = 1; i < CH; i++) drive(1'b1, 1'b0, 1'((8'hC3 >> i) & 8'h01));
    chk("early_new_y", y, 8'hC3);
    chk("early_new_valid", valid, 1);

    // Early frame exactly at the last slot takes the error path.
    for (int i = 0; i < CH - 1; i++) drive(1'b1, i == 0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    chk("last_early_err", sync_err, 1);
    chk("last_early_valid", valid, 0);
    chk("last_early_y", y, 8'hC3);
    for (int i = 1; i < CH; i++) drive(1'b1, 1'b0, 1'((8'h6E >> i) & 8'h01));
    chk("last_early_new_y", y, 8'h6E);

    // Missing frame marker drops lock; bits ignored until the next marker.
    drive(1'b1, 1'b0, 1'b1);
    chk("miss_err", sync_err, 1);
    chk("miss_locked", locked, 0);
    vcount = 0;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("miss_no_valid", vcount, 0);
    chk("miss_y_hold", y, 8'h6E);
    send_frame(8'h96, 0);
    chk("miss_recover_y", y, 8'h96);

    // Asynchronous reset mid-frame, then a clean frame.
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b1);
    chk("rst_pre_slot", slot, 4);
    async_reset();
    drive(1'b1, 1'b0, 1'b1);
    chk("rst_needs_marker", locked, 0);
    send_frame(8'h4B, 2);
    chk("rst_recover_y", y, 8'h4B);

    // Frame marker with en=0 at slot 3 in LOCK is ignored.
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'((8'hE1 >> i) & 8'h01));
    drive(1'b0, 1'b1, 1'b1);
    chk("lock_noen_slot", slot, 3);
    chk("lock_noen_err", sync_err, 0);
    for (int i = 3; i < CH; i++) drive(1'b1, 1'b0, 1'((8'hE1 >> i) & 8'h01));
    chk("lock_noen_y", y, 8'hE1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
